// File: rtl/sort_mon_pkg.sv
// Shared types and sizing for the sort-result monitor and its checker.
package sort_mon_pkg;

    localparam int NUM_ELE   = 5;
    localparam int ELE_W     = 64;
    localparam int IDX_W     = 3;
    localparam int ELE_BYTES = 8;

    // Index of the final stream element; the handshake on it ends the stream.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELE - 1);

    // Byte offset of the last element from the window base.
    localparam logic [ELE_W-1:0] WIN_SPAN = ELE_W'(ELE_BYTES * (NUM_ELE - 1));

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        STREAM  = 2'd1,
        DONE    = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sort_checker.sv
// Combinational verdict: are the elements signed non-decreasing?
module sort_checker
    import sort_mon_pkg::*;
(
    input  logic [NUM_ELE-1:0][ELE_W-1:0] ele_i,
    output logic                          sorted_o
);

    logic [NUM_ELE-2:0] pair_ok;

    // Each neighbour pair is compared as two's-complement; equal counts as ordered.
    generate
        for (genvar k = 0; k < NUM_ELE - 1; k++) begin : g_pair
            assign pair_ok[k] = $signed(ele_i[k]) <= $signed(ele_i[k+1]);
        end
    endgenerate

    assign sorted_o = &pair_ok;

endmodule

// File: rtl/sort_result_monitor.sv
// Snoops the data-memory store port, mirrors the result window, and on the
// done store freezes the results, latches a sorted verdict and streams them.
module sort_result_monitor
    import sort_mon_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter logic [63:0] DONE_ADDR = 64'd40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             mem_write,
    input  logic [63:0]      mem_addr,
    input  logic [63:0]      mem_wdata,
    output logic [ELE_W-1:0] ele1,
    output logic [ELE_W-1:0] ele2,
    output logic [ELE_W-1:0] ele3,
    output logic [ELE_W-1:0] ele4,
    output logic [ELE_W-1:0] ele5,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ELE_W-1:0] out_data,
    output logic             out_last,
    output logic             done,
    output logic             is_sorted,
    output logic             overrun
);

    mon_state_e                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_ELE-1:0][ELE_W-1:0] ele_q, ele_d, cap_ele;
    logic                         sorted_q, sorted_d;
    logic                         ovr_q, ovr_d;

    logic [ELE_W-1:0]             win_off;
    logic [IDX_W-1:0]             win_idx;
    logic                         done_hit, win_hit, chk_sorted;

    // Store decode. The done address wins if it overlaps the window.
    assign win_off  = mem_addr - BASE_ADDR;
    assign win_idx  = win_off[3 +: IDX_W];
    assign done_hit = mem_write && (mem_addr == DONE_ADDR);
    assign win_hit  = mem_write && !done_hit && (mem_addr >= BASE_ADDR) &&
                      (win_off <= WIN_SPAN) && (mem_addr[2:0] == 3'b000);

    // Element view including this cycle's window store, so the verdict sees it.
    always_comb begin
        cap_ele = ele_q;
        if (win_hit) cap_ele[win_idx] = mem_wdata;
    end

    sort_checker u_chk (
        .ele_i    (cap_ele),
        .sorted_o (chk_sorted)
    );

    // Next-state: capture, freeze-and-stream, hold; clear overrides everything.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ele_d    = ele_q;
        sorted_d = sorted_q;
        ovr_d    = ovr_q;
        if (clear) begin
            state_d  = CAPTURE;
            idx_d    = '0;
            ele_d    = '0;
            sorted_d = 1'b0;
            ovr_d    = 1'b0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    ele_d = cap_ele;
                    if (done_hit) begin
                        state_d  = STREAM;
                        idx_d    = '0;
                        sorted_d = chk_sorted;
                    end
                end
                STREAM: begin
                    if (win_hit || done_hit) ovr_d = 1'b1;
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) state_d = DONE;
                        else                   idx_d   = idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (win_hit || done_hit) ovr_d = 1'b1;
                end
                default: state_d = CAPTURE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CAPTURE;
            idx_q    <= '0;
            ele_q    <= '0;
            sorted_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ele_q    <= ele_d;
            sorted_q <= sorted_d;
            ovr_q    <= ovr_d;
        end
    end

    // Outputs decode registered state only; out_ready never reaches them.
    assign out_valid = (state_q == STREAM);
    assign out_data  = out_valid ? ele_q[idx_q] : '0;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign done      = (state_q != CAPTURE);
    assign is_sorted = sorted_q;
    assign overrun   = ovr_q;

    assign ele1 = ele_q[0];
    assign ele2 = ele_q[1];
    assign ele3 = ele_q[2];
    assign ele4 = ele_q[3];
    assign ele5 = ele_q[4];

endmodule

// File: tb/tb_sort_result_monitor.sv
// Randomized + directed bench against a queue-based reference model.
module tb_sort_result_monitor;

    localparam logic [63:0] BASE = 64'd0;
    localparam logic [63:0] DADR = 64'd40;

    logic        clk, reset, clear, mem_write, out_ready;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] ele1, ele2, ele3, ele4, ele5, out_data;
    logic        out_valid, out_last, done, is_sorted, overrun;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: element array, frozen flag, queue of pending stream words.
    longint m_ele[5];
    bit     m_frozen, m_sorted, m_ovr;
    longint m_q[$];

    sort_result_monitor #(.BASE_ADDR(BASE), .DONE_ADDR(DADR)) dut (
        .clk(clk), .reset(reset), .clear(clear), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ele1(ele1), .ele2(ele2), .ele3(ele3), .ele4(ele4), .ele5(ele5),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done), .is_sorted(is_sorted), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_sorted();
        for (int i = 0; i < 4; i++)
            if (m_ele[i] > m_ele[i+1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit in_window(input logic [63:0] a);
        return (a >= BASE) && (a <= BASE + 64'd32) && (a[2:0] == 3'b000) && (a != DADR);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_ele[i] = 0;
        m_frozen = 0; m_sorted = 0; m_ovr = 0;
        m_q.delete();
    endtask

    // Apply the rules for one clock edge using the inputs held across it.
    task automatic model_step();
        if (clear) begin
            model_reset();
        end else if (!m_frozen) begin
            if (mem_write && mem_addr == DADR) begin
                m_frozen = 1;
                m_sorted = model_sorted();
                for (int i = 0; i < 5; i++) m_q.push_back(m_ele[i]);
            end else if (mem_write && in_window(mem_addr)) begin
                m_ele[(mem_addr - BASE) >> 3] = longint'(mem_wdata);
            end
        end else begin
            if (mem_write && (mem_addr == DADR || in_window(mem_addr))) m_ovr = 1;
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        end
    endtask

    task automatic check_all();
        chk("ele1", ele1, m_ele[0]);
        chk("ele2", ele2, m_ele[1]);
        chk("ele3", ele3, m_ele[2]);
        chk("ele4", ele4, m_ele[3]);
        chk("ele5", ele5, m_ele[4]);
        chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 64'd0);
        chk("out_last", 64'(out_last), 64'(m_q.size() == 1));
        chk("done", 64'(done), 64'(m_frozen));
        chk("is_sorted", 64'(is_sorted), 64'(m_sorted));
        chk("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic store(input logic [63:0] a, input longint d);
        mem_write = 1'b1; mem_addr = a; mem_wdata = d;
        cyc();
        mem_write = 1'b0;
    endtask

    task automatic load5(input longint a0, a1, a2, a3, a4);
        store(64'd0, a0); store(64'd8, a1); store(64'd16, a2);
        store(64'd24, a3); store(64'd32, a4);
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(); clear = 1'b0;
    endtask

    initial begin
        logic [63:0] addr_tbl [10];
        reset = 1'b0; clear = 1'b0; mem_write = 1'b0; out_ready = 1'b0;
        mem_addr = '0; mem_wdata = '0;
        model_reset();
        #2 check_all();
        #8 reset = 1'b1;

        // Capture, then stream an unsorted set at full rate.
        load5(5, -3, 9, 1, 7);
        out_ready = 1'b1;
        store(DADR, 123);
        repeat (7) cyc();
        do_clear();

        // Sorted set under backpressure, with an overrun store mid-stream.
        load5(-3, 1, 5, 7, 9);
        out_ready = 1'b0;
        store(DADR, 0);
        begin
            bit pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
            for (int i = 0; i < 12; i++) begin
                out_ready = pat[i];
                if (i == 3) store(64'd16, 999);
                else        cyc();
            end
        end
        store(DADR, 1);
        do_clear();

        // Clear beats a simultaneous store; misaligned/out-of-window ignored.
        clear = 1'b1; mem_write = 1'b1; mem_addr = 64'd8; mem_wdata = 64'd77;
        cyc();
        clear = 1'b0; mem_write = 1'b0;
        store(64'd12, 55);
        store(64'd48, 66);

        // All-equal set is sorted.
        load5(4, 4, 4, 4, 4);
        out_ready = 1'b1;
        store(DADR, 0);
        repeat (6) cyc();
        do_clear();

        // Async reset with the stream sitting at index 2.
        load5(10, 20, 30, 40, 50);
        store(DADR, 0);
        repeat (2) cyc();
        out_ready = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        reset = 1'b1;

        // Randomized traffic.
        addr_tbl = '{64'd0, 64'd8, 64'd16, 64'd24, 64'd32, 64'd40, 64'd12, 64'd48, 64'd4, 64'd36};
        for (int n = 0; n < 3000; n++) begin
            clear     = ($urandom_range(0, 39) == 0);
            mem_write = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) mem_addr = {$urandom, $urandom};
            else mem_addr = addr_tbl[($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 9)];
            if ($urandom_range(0, 1) == 1) mem_wdata = 64'(longint'($urandom_range(0, 20)) - 64'sd10);
            else                           mem_wdata = {$urandom, $urandom};
            out_ready = $urandom_range(0, 2) != 0;
            cyc();
        end
        clear = 1'b0; mem_write = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sort_result_monitor.md
# sort_result_monitor

Observer/responder for the processor's data-memory store port. Snoops stores into a five-doubleword result window and mirrors them on `ele1`..`ele5`. When the program signals completion by storing to a done address, the block freezes the results, latches a signed-ascending "sorted" verdict, and streams the five doublewords to a consumer over a valid/ready handshake. It sits beside `RISC_V_Processor` at top level and gives benches and on-chip consumers a cycle-exact view of the sort result.

## Interface
- `BASE_ADDR`, default 64'd0: byte address of element 0; element i is at `BASE_ADDR + 8*i`, i = 0..4.
- `DONE_ADDR`, default 64'd40: a store here, with any data, marks completion.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `clear`  in  1  synchronous; returns the block to CAPTURE and zeroes the elements.
- `mem_write`  in  1  store strobe from the processor data-memory port.
- `mem_addr`  in  64  store byte address.
- `mem_wdata`  in  64  store data.
- `ele1`..`ele5`  out  64 each  captured elements 0..4.
- `out_valid`  out  1  stream element available.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  64  current stream element.
- `out_last`  out  1  high with element 4.
- `done`  out  1  capture frozen (STREAM or DONE state).
- `is_sorted`  out  1  latched verdict: elements are signed non-decreasing.
- `overrun`  out  1  sticky flag: a window or done store arrived while frozen.

## Operation
- States: CAPTURE, STREAM, DONE. Reset state is CAPTURE.
- CAPTURE:
  - A store with `mem_addr` in [BASE_ADDR, BASE_ADDR+32] and `mem_addr[2:0]==0` writes `mem_wdata` to element `(mem_addr-BASE_ADDR)>>3`.
  - Misaligned or out-of-window stores are ignored.
  - A store to `DONE_ADDR` latches `is_sorted` from the five element registers, including any write to a window address in that same cycle, and moves to STREAM with index 0.
  - If `DONE_ADDR` lies inside the window, the store is treated as done only and the element is not written.
- STREAM:
  - `out_valid`=1 and `out_data` = element[index].
  - `out_last` = (index==4).
  - On `out_valid && out_ready`, index increments; the transfer with index 4 moves the block to DONE.
- DONE: `out_valid`=0. The block holds until `clear` or reset.
- In STREAM and DONE, window and done stores are dropped and set `overrun`. The elements do not change.
- `clear`: state CAPTURE, elements 0, index 0, `is_sorted` 0, `overrun` 0. `clear` beats a simultaneous store or handshake.
- `is_sorted` comparisons are 64-bit two's-complement signed; equal neighbours count as sorted.
- The index is 3 bits and never exceeds 4; it has no wrap.

## Timing
- Reset values: all `ele` outputs 0, `out_valid` 0, `out_data` 0, `out_last` 0, `done` 0, `is_sorted` 0, `overrun` 0.
- Store at edge N makes the new `ele` value visible after edge N. Latency is 1 cycle.
- Done store at edge N: after N, `done`=1, `out_valid`=1, `out_data`=element 0.
- With `out_ready` held high, one element is transferred per cycle. Five transfers occupy edges N+1..N+5; after N+5 the block is in DONE.
- `out_data`/`out_last` are stable while `out_valid && !out_ready`. `out_valid` never drops before its handshake.
- `out_data`, `out_last` and `out_valid` are decoded from registered state with no combinational path from `out_ready`.
- Reset asserted mid-stream forces all outputs to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `sort_mon_pkg`:
  - State enum (CAPTURE/STREAM/DONE).
  - `NUM_ELE`=5.
  - `ELE_W`=64.
  - Element-index width.
- Sub-module `sort_checker`: purely combinational; five signed 64-bit inputs produce a sorted bit. It is reusable by benches.
- The top level contains the store decoder, element registers, FSM and stream mux.

## Test plan
- Reset low at time 0, release at 10: all outputs are 0 and the state is CAPTURE. Stores to addresses 0,8,16,24,32 with data 5,-3,9,1,7 give `ele1`..`ele5` = 5,-3,9,1,7 one cycle after each store.
- Done store while holding -3,1,5,7,9 with `out_ready`=1: `is_sorted`=1, and the stream emits -3,1,5,7,9 on 5 consecutive cycles with `out_last` only on 9. The block then reaches DONE.
- Done store with 5,-3,9,1,7: `is_sorted`=0. Also check equal values 4,4,4,4,4: `is_sorted`=1.
- Backpressure: toggle `out_ready` 1,0,0,1,... `out_data` holds steady while stalled, and no element is skipped or repeated.
- Store to 16 during STREAM: `ele3` is unchanged, `overrun`=1. Then `clear`: everything returns to 0 and capture resumes. `clear` and a store in the same cycle: the element stays 0.
- Misaligned store to address 12 and out-of-window store to 48: no element changes. Reset asserted at stream index 2: outputs return to 0 immediately.
